// File: rtl/lsu_dbus_if_pkg.sv
// rtl/lsu_dbus_if_pkg.sv - shared encodings and bus types for the load/store unit
package lsu_dbus_if_pkg;

  localparam int LSU_XLEN            = 32;
  localparam int LSU_TIMEOUT_DEFAULT = 16;

  localparam logic [1:0] LSU_SIZE_BYTE = 2'b00;
  localparam logic [1:0] LSU_SIZE_HALF = 2'b01;
  localparam logic [1:0] LSU_SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } type_lsu_state_e;

  typedef struct packed {
    logic                req;
    logic                w_en;
    logic [LSU_XLEN-1:0] addr;
    logic [LSU_XLEN-1:0] w_data;
    logic [3:0]          sel_byte;
  } type_dbus2peri_s;

  typedef struct packed {
    logic [LSU_XLEN-1:0] r_data;
    logic                ack;
  } type_peri2dbus_s;

endpackage

// File: rtl/lsu_lane_steer.sv
// rtl/lsu_lane_steer.sv - byte-lane select, store replication, load extraction and misalign check
module lsu_lane_steer
  import lsu_dbus_if_pkg::*;
#(
  parameter int XLEN = LSU_XLEN
) (
  input  logic [1:0]      req_size,
  input  logic [1:0]      req_addr_lo,
  input  logic [XLEN-1:0] req_wdata,
  output logic [3:0]      sel_byte,
  output logic [XLEN-1:0] w_data,
  output logic            misalign,
  input  logic [1:0]      rsp_size,
  input  logic [1:0]      rsp_addr_lo,
  input  logic            rsp_unsigned,
  input  logic [XLEN-1:0] bus_rdata,
  output logic [XLEN-1:0] rdata_ext
);

  logic [XLEN-1:0] shifted;

  // Request side: lanes enabled, replicated store data and alignment check.
  // Size 2'b11 falls into the word branch.
  always_comb begin
    sel_byte = 4'b0000;
    w_data   = req_wdata;
    misalign = 1'b0;
    case (req_size)
      LSU_SIZE_BYTE: begin
        sel_byte = 4'b0001 << req_addr_lo;
        w_data   = {(XLEN/8){req_wdata[7:0]}};
      end
      LSU_SIZE_HALF: begin
        sel_byte = req_addr_lo[1] ? 4'b1100 : 4'b0011;
        w_data   = {(XLEN/16){req_wdata[15:0]}};
        misalign = req_addr_lo[0];
      end
      default: begin
        sel_byte = 4'b1111;
        w_data   = req_wdata;
        misalign = |req_addr_lo;
      end
    endcase
  end

  // Response side: move the addressed lane down to bit 0, then extend.
  always_comb begin
    shifted   = bus_rdata >> {rsp_addr_lo, 3'b000};
    rdata_ext = shifted;
    case (rsp_size)
      LSU_SIZE_BYTE:
        rdata_ext = rsp_unsigned ? {{(XLEN-8){1'b0}}, shifted[7:0]}
                                 : {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LSU_SIZE_HALF:
        rdata_ext = rsp_unsigned ? {{(XLEN-16){1'b0}}, shifted[15:0]}
                                 : {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      default:
        rdata_ext = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_dbus_if.sv
// rtl/lsu_dbus_if.sv - load/store unit driving the data bus with stall, misalign and timeout handling
module lsu_dbus_if
  import lsu_dbus_if_pkg::*;
#(
  parameter int XLEN           = LSU_XLEN,
  parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            lsu_req_i,
  input  logic            lsu_we_i,
  input  logic [1:0]      lsu_size_i,
  input  logic            lsu_unsigned_i,
  input  logic [XLEN-1:0] lsu_addr_i,
  input  logic [XLEN-1:0] lsu_wdata_i,
  input  logic            lsu_flush_i,
  output logic            lsu_stall_o,
  output logic            lsu_done_o,
  output logic [XLEN-1:0] lsu_rdata_o,
  output logic            lsu_ld_misalign_o,
  output logic            lsu_st_misalign_o,
  output logic            lsu_bus_err_o,
  output logic [XLEN-1:0] lsu_err_addr_o,
  output type_dbus2peri_s lsu2dbus_o,
  input  type_peri2dbus_s dbus2lsu_i
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  type_lsu_state_e state, state_nxt;

  logic [XLEN-1:0]  addr_q;
  logic [XLEN-1:0]  bus_addr_q;
  logic [XLEN-1:0]  wdata_q;
  logic [XLEN-1:0]  rdata_q;
  logic [XLEN-1:0]  err_addr_q;
  logic [3:0]       sel_q;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic             we_q;
  logic             flush_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;
  logic             ld_mis_q;
  logic             st_mis_q;
  logic             bus_err_q;

  logic [3:0]       lane_sel;
  logic [XLEN-1:0]  lane_wdata;
  logic [XLEN-1:0]  lane_rdata;
  logic             lane_misalign;

  logic accept;
  logic accept_ok;
  logic ack;
  logic timeout;
  logic squash;

  assign accept    = lsu_req_i & ~lsu_flush_i;
  assign accept_ok = accept & ~lane_misalign;
  assign ack       = dbus2lsu_i.ack;
  // Ack takes priority over an expiring counter.
  assign timeout   = (cnt_q == CNT_LAST) & ~ack;
  // A flush seen at any point of the access hides its result.
  assign squash    = flush_q | lsu_flush_i;

  lsu_lane_steer #(.XLEN(XLEN)) u_lane (
    .req_size     (lsu_size_i),
    .req_addr_lo  (lsu_addr_i[1:0]),
    .req_wdata    (lsu_wdata_i),
    .sel_byte     (lane_sel),
    .w_data       (lane_wdata),
    .misalign     (lane_misalign),
    .rsp_size     (size_q),
    .rsp_addr_lo  (addr_q[1:0]),
    .rsp_unsigned (unsigned_q),
    .bus_rdata    (dbus2lsu_i.r_data),
    .rdata_ext    (lane_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: loads sit in REQ until ack, stores pass through REQ once then WAIT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept_ok) state_nxt = REQ;
      REQ: begin
        if (ack || timeout) state_nxt = IDLE;
        else if (we_q)      state_nxt = WAIT;
      end
      WAIT: if (ack || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bus drive and stall; request lanes were latched at accept.
  always_comb begin
    lsu2dbus_o          = '0;
    lsu2dbus_o.req      = (state == REQ);
    lsu2dbus_o.w_en     = (state == REQ) & we_q;
    lsu2dbus_o.addr     = bus_addr_q;
    lsu2dbus_o.w_data   = wdata_q;
    lsu2dbus_o.sel_byte = sel_q;
    lsu_stall_o         = (state != IDLE) | accept_ok;
  end

  // Access registers, timeout counter and one-cycle result pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q     <= '0;
      bus_addr_q <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      err_addr_q <= '0;
      sel_q      <= '0;
      size_q     <= '0;
      unsigned_q <= 1'b0;
      we_q       <= 1'b0;
      flush_q    <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
      ld_mis_q   <= 1'b0;
      st_mis_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ld_mis_q  <= 1'b0;
      st_mis_q  <= 1'b0;
      bus_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && lane_misalign) begin
            ld_mis_q   <= ~lsu_we_i;
            st_mis_q   <= lsu_we_i;
            err_addr_q <= lsu_addr_i;
          end else if (accept) begin
            addr_q     <= lsu_addr_i;
            bus_addr_q <= {lsu_addr_i[XLEN-1:2], 2'b00};
            wdata_q    <= lane_wdata;
            sel_q      <= lane_sel;
            size_q     <= lsu_size_i;
            unsigned_q <= lsu_unsigned_i;
            we_q       <= lsu_we_i;
            flush_q    <= 1'b0;
            cnt_q      <= '0;
          end
        end
        REQ, WAIT: begin
          flush_q <= squash;
          if (ack) begin
            if (!squash) begin
              done_q  <= 1'b1;
              rdata_q <= we_q ? '0 : lane_rdata;
            end
          end else if (timeout) begin
            if (!squash) begin
              bus_err_q  <= 1'b1;
              err_addr_q <= addr_q;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign lsu_done_o        = done_q;
  assign lsu_rdata_o       = rdata_q;
  assign lsu_ld_misalign_o = ld_mis_q;
  assign lsu_st_misalign_o = st_mis_q;
  assign lsu_bus_err_o     = bus_err_q;
  assign lsu_err_addr_o    = err_addr_q;

endmodule

// File: tb/tb_lsu_dbus_if.sv
// tb/tb_lsu_dbus_if.sv - self-checking bench for lsu_dbus_if
module tb_lsu_dbus_if;
  import lsu_dbus_if_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsu_req = 1'b0;
  logic        lsu_we = 1'b0;
  logic [1:0]  lsu_size = 2'b00;
  logic        lsu_unsigned = 1'b0;
  logic [31:0] lsu_addr = '0;
  logic [31:0] lsu_wdata = '0;
  logic        lsu_flush = 1'b0;
  logic        lsu_stall, lsu_done, lsu_ld_mis, lsu_st_mis, lsu_bus_err;
  logic [31:0] lsu_rdata, lsu_err_addr;
  type_dbus2peri_s bus_o;
  type_peri2dbus_s bus_i;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit in_rst = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  lsu_dbus_if #(.XLEN(32), .TIMEOUT_CYCLES(16)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .lsu_req_i         (lsu_req),
    .lsu_we_i          (lsu_we),
    .lsu_size_i        (lsu_size),
    .lsu_unsigned_i    (lsu_unsigned),
    .lsu_addr_i        (lsu_addr),
    .lsu_wdata_i       (lsu_wdata),
    .lsu_flush_i       (lsu_flush),
    .lsu_stall_o       (lsu_stall),
    .lsu_done_o        (lsu_done),
    .lsu_rdata_o       (lsu_rdata),
    .lsu_ld_misalign_o (lsu_ld_mis),
    .lsu_st_misalign_o (lsu_st_mis),
    .lsu_bus_err_o     (lsu_bus_err),
    .lsu_err_addr_o    (lsu_err_addr),
    .lsu2dbus_o        (bus_o),
    .dbus2lsu_i        (bus_i)
  );

  // Bus slave: 4 KiB at address 0 reads with zero wait and acks writes one cycle later;
  // everything above 0xFFF never answers.
  logic [31:0] slv_mem [0:1023];
  logic        wr_ack_q = 1'b0;
  logic        live;

  always_comb begin
    live         = (bus_o.addr[31:12] == 20'd0);
    bus_i        = '0;
    bus_i.ack    = (bus_o.req & ~bus_o.w_en & live) | wr_ack_q;
    bus_i.r_data = slv_mem[bus_o.addr[11:2]];
  end

  always @(posedge clk) begin
    wr_ack_q <= bus_o.req & bus_o.w_en & live;
    if (bus_o.req && bus_o.w_en && live)
      for (int b = 0; b < 4; b++)
        if (bus_o.sel_byte[b]) slv_mem[bus_o.addr[11:2]][8*b +: 8] <= bus_o.w_data[8*b +: 8];
  end

  // Reference model: byte-addressed memory plus one expected-outcome record per request.
  localparam int K_LD = 0, K_ST = 1, K_LMIS = 2, K_SMIS = 3, K_BERR = 4, K_SQ = 5;

  typedef struct {
    int          acc, req_lo, req_hi, fin, kind;
    logic [31:0] rdata, eaddr, baddr, wdata;
    logic [3:0]  sel;
    logic        we;
  } exp_t;

  exp_t        q[$];
  logic [7:0]  mdl [0:4095];
  int          last_cyc = -1;
  logic [31:0] last_rdata = '0;
  logic [31:0] last_eaddr = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic exp_t mk_rec(input logic we, input logic [1:0] size, input logic uns,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  input bit flushed, input int acc);
    exp_t r;
    int   nb;
    int   off;
    nb       = nbytes(size);
    off      = int'(addr % 4);
    r.acc    = acc;
    r.we     = we;
    r.eaddr  = addr;
    r.baddr  = addr - 32'(off);
    r.sel    = '0;
    r.wdata  = '0;
    r.rdata  = '0;
    for (int i = 0; i < nb; i++) r.sel[(off + i) % 4] = 1'b1;
    for (int j = 0; j < 4; j++) r.wdata[8*j +: 8] = data[8*(j % nb) +: 8];
    if ((addr % nb) != 0) begin
      r.kind = we ? K_SMIS : K_LMIS; r.fin = acc + 1; r.req_lo = 1; r.req_hi = 0;
    end else if (addr >= 32'h1000) begin
      r.kind = K_BERR; r.req_lo = acc + 1; r.req_hi = we ? acc + 1 : acc + 16; r.fin = acc + 17;
    end else if (!we) begin
      r.kind = K_LD; r.req_lo = acc + 1; r.req_hi = acc + 1; r.fin = acc + 2;
      for (int i = 0; i < nb; i++) r.rdata = r.rdata | (32'(mdl[addr + 32'(i)]) << (8*i));
      if (!uns && nb < 4 && r.rdata[8*nb-1]) r.rdata = r.rdata | ~((32'h1 << (8*nb)) - 1);
    end else begin
      r.kind = K_ST; r.req_lo = acc + 1; r.req_hi = acc + 1; r.fin = acc + 3;
    end
    if (flushed && r.kind != K_SMIS && r.kind != K_LMIS) r.kind = K_SQ;
    return r;
  endfunction

  // Per-cycle comparison of every DUT output against the head expectation.
  always @(negedge clk) begin : cmp
    exp_t h;
    bit   have;
    logic e_stall, e_req, e_done, e_lm, e_sm, e_be;
    if (!in_rst) begin
      have = (q.size() > 0);
      e_stall = 0; e_req = 0; e_done = 0; e_lm = 0; e_sm = 0; e_be = 0;
      if (have) begin
        h       = q[0];
        e_stall = (h.kind != K_LMIS && h.kind != K_SMIS) && cyc >= h.acc && cyc < h.fin;
        e_req   = cyc >= h.req_lo && cyc <= h.req_hi;
        e_done  = cyc == h.fin && (h.kind == K_LD || h.kind == K_ST);
        e_lm    = cyc == h.fin && h.kind == K_LMIS;
        e_sm    = cyc == h.fin && h.kind == K_SMIS;
        e_be    = cyc == h.fin && h.kind == K_BERR;
      end
      check("stall", 32'(lsu_stall), 32'(e_stall));
      check("bus_req", 32'(bus_o.req), 32'(e_req));
      check("done", 32'(lsu_done), 32'(e_done));
      check("ld_misalign", 32'(lsu_ld_mis), 32'(e_lm));
      check("st_misalign", 32'(lsu_st_mis), 32'(e_sm));
      check("bus_err", 32'(lsu_bus_err), 32'(e_be));
      if (e_req) begin
        check("bus_addr", bus_o.addr, h.baddr);
        check("bus_sel", 32'(bus_o.sel_byte), 32'(h.sel));
        check("bus_w_en", 32'(bus_o.w_en), 32'(h.we));
        if (h.we) check("bus_wdata", bus_o.w_data, h.wdata);
      end
      if (e_done) check("rdata", lsu_rdata, h.rdata);
      if (e_lm || e_sm || e_be) check("err_addr", lsu_err_addr, h.eaddr);
      if (lsu_done || lsu_ld_mis || lsu_st_mis || lsu_bus_err) begin
        last_cyc   = cyc;
        last_rdata = lsu_rdata;
        last_eaddr = lsu_err_addr;
      end
      if (have && cyc >= h.fin) void'(q.pop_front());
    end
  end

  task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data,
                       input int flush_at, output int acc);
    exp_t r;
    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = we; lsu_size = size; lsu_unsigned = uns;
    lsu_addr = addr; lsu_wdata = data;
    acc = cyc;
    r = mk_rec(we, size, uns, addr, data, flush_at >= 0, acc);
    q.push_back(r);
    if (we && (r.kind == K_ST || r.kind == K_SQ))
      for (int i = 0; i < nbytes(size); i++) mdl[addr + 32'(i)] = data[8*i +: 8];
    @(posedge clk); #1;
    lsu_req = 1'b0; lsu_we = 1'b0; lsu_wdata = '0;
    while (cyc <= r.fin) begin
      lsu_flush = (flush_at >= 0) && (cyc - acc == flush_at);
      @(posedge clk); #1;
    end
    lsu_flush = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_req"}, 32'(bus_o.req), 32'h0);
    check({tag, "_w_en"}, 32'(bus_o.w_en), 32'h0);
    check({tag, "_addr"}, bus_o.addr, 32'h0);
    check({tag, "_w_data"}, bus_o.w_data, 32'h0);
    check({tag, "_sel"}, 32'(bus_o.sel_byte), 32'h0);
    check({tag, "_rdata"}, lsu_rdata, 32'h0);
    check({tag, "_err_addr"}, lsu_err_addr, 32'h0);
    check({tag, "_pulses"}, {27'd0, lsu_stall, lsu_done, lsu_ld_mis, lsu_st_mis, lsu_bus_err}, 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc;
    int prev;
    for (int i = 0; i < 1024; i++) slv_mem[i] = '0;
    for (int i = 0; i < 4096; i++) mdl[i] = '0;
    slv_mem[32'h100 >> 2] = 32'h8899AABB;
    mdl[32'h100] = 8'hBB; mdl[32'h101] = 8'hAA; mdl[32'h102] = 8'h99; mdl[32'h103] = 8'h88;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    in_rst = 1'b0;

    do_op(0, 2'd0, 0, 32'h103, 0, -1, acc);
    check("lb_val", last_rdata, 32'hFFFFFF88);
    check("lb_lat", 32'(last_cyc - acc), 32'd2);
    do_op(0, 2'd0, 1, 32'h102, 0, -1, acc);
    check("lbu_val", last_rdata, 32'h00000099);
    do_op(0, 2'd1, 0, 32'h102, 0, -1, acc);
    check("lh_val", last_rdata, 32'hFFFF8899);
    do_op(0, 2'd1, 1, 32'h100, 0, -1, acc);
    check("lhu_val", last_rdata, 32'h0000AABB);
    check("lhu_lat", 32'(last_cyc - acc), 32'd2);

    do_op(1, 2'd0, 0, 32'h101, 32'h12, -1, acc);
    check("sb_lat", 32'(last_cyc - acc), 32'd3);
    check("sb_rdata_zero", last_rdata, 32'h0);
    do_op(0, 2'd2, 0, 32'h100, 0, -1, acc);
    check("lw_after_sb", last_rdata, 32'h889912BB);
    do_op(1, 2'd1, 0, 32'h102, 32'h5566, -1, acc);
    do_op(0, 2'd2, 0, 32'h100, 0, -1, acc);
    check("lw_after_sh", last_rdata, 32'h556612BB);
    do_op(0, 2'd3, 0, 32'h100, 0, -1, acc);
    check("lw_size3", last_rdata, 32'h556612BB);
    do_op(0, 2'd0, 0, 32'h100, 0, -1, acc);

    do_op(0, 2'd2, 0, 32'h102, 0, -1, acc);
    check("lw_mis_eaddr", last_eaddr, 32'h102);
    check("lw_mis_lat", 32'(last_cyc - acc), 32'd1);
    do_op(1, 2'd1, 0, 32'h105, 32'hABCD, -1, acc);
    check("sh_mis_eaddr", last_eaddr, 32'h105);

    do_op(0, 2'd2, 0, 32'h2000, 0, -1, acc);
    check("to_lat", 32'(last_cyc - acc), 32'd17);
    check("to_eaddr", last_eaddr, 32'h2000);
    do_op(1, 2'd2, 0, 32'h3004, 32'h11223344, -1, acc);
    check("sto_eaddr", last_eaddr, 32'h3004);

    prev = last_cyc;
    do_op(1, 2'd2, 0, 32'h104, 32'hDEADBEEF, 2, acc);
    check("flush_no_done", 32'(last_cyc), 32'(prev));
    do_op(0, 2'd2, 0, 32'h104, 0, -1, acc);
    check("flush_committed", last_rdata, 32'hDEADBEEF);

    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_flush = 1'b1; lsu_size = 2'd2; lsu_addr = 32'h100;
    @(posedge clk); #1;
    lsu_req = 1'b0; lsu_flush = 1'b0;
    repeat (3) @(posedge clk);

    @(posedge clk); #1;
    lsu_req = 1'b1; lsu_we = 1'b0; lsu_size = 2'd2; lsu_unsigned = 1'b0; lsu_addr = 32'h100;
    acc = cyc;
    q.push_back(mk_rec(0, 2'd2, 0, 32'h100, 0, 0, acc));
    @(posedge clk); #1;
    lsu_req = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    in_rst = 1'b1;
    q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    in_rst = 1'b0;

    do_op(0, 2'd1, 0, 32'h102, 0, -1, acc);
    check("post_reset_lh", last_rdata, 32'h00005566);
    check("post_reset_lat", 32'(last_cyc - acc), 32'd2);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
